branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side branch predictor: bimodal BHT of 2-bit counters plus a direct-mapped BTB.
//  Predicts direction/target for the fetch PC; trained at resolve time by the execute-stage
//  branch comparator (taken outcome) and target adder. Flags mispredicts; counts them.
// PARAMETERS
//  BHT_ENTRIES  64   direction counters, power of 2; IDX_W = $clog2(BHT_ENTRIES)
//  BTB_ENTRIES  16   BTB entries, power of 2; BTB_W = $clog2(BTB_ENTRIES)
// PORTS
//  clk               in   1      clock, all state on rising edge
//  rst_n             in   1      asynchronous active-low reset
//  pc_i              in   32     fetch PC to predict
//  pred_taken_o      out  1      predicted taken
//  pred_target_o     out  32     predicted target (valid when pred_taken_o)
//  pred_idx_o        out  IDX_W  BHT index used; carried down pipe, returned as upd_idx_i
//  upd_valid_i       in   1      resolved control-flow instr this cycle
//  upd_pc_i          in   32     PC of resolved instr
//  upd_idx_i         in   IDX_W  pred_idx_o captured at its fetch
//  upd_is_cond_i     in   1      1 = conditional branch, 0 = unconditional jump
//  upd_taken_i       in   1      actual outcome (comparator result; 1 for jumps)
//  upd_target_i      in   32     actual target
//  upd_pred_taken_i  in   1      prediction made at fetch
//  upd_pred_target_i in   32     predicted target at fetch
//  mispredict_o      out  1      resolve-cycle mispredict flag
//  mispred_cnt_o     out  32     saturating mispredict count
// BEHAVIOUR
//  Reset: all BHT counters = WNT (2'b01), BTB valids = 0, GHR = 0, mispred_cnt_o = 0.
//   Lookup outputs are combinational and read the reset state; pred_taken_o = 0.
//  Lookup (combinational, 0 cycles): BTB idx = pc_i[BTB_W+1:2], tag = pc_i[31:BTB_W+2].
//   hit = valid & tag match. pred_taken_o = hit & (~is_cond | bht[idx][1]).
//   pred_target_o = entry target on hit, else pc_i + 4. pred_idx_o = idx.
//  Update (registered, visible to lookup the next cycle, only when upd_valid_i):
//   BHT: only if upd_is_cond_i; bht[upd_idx_i] +1 if taken, -1 if not.
//   Saturates at ST (11) and SNT (00); no wrap.
//   BTB: if upd_taken_i, write {valid=1, tag, target, is_cond} at upd_pc_i's slot.
//   This overwrites any alias. A not-taken outcome never allocates or invalidates.
//  mispredict_o = upd_valid_i & ((upd_taken_i != upd_pred_taken_i) |
//   (upd_taken_i & upd_target_i != upd_pred_target_i)); combinational, same cycle.
//  mispred_cnt_o: +1 on edge where mispredict_o = 1; holds at 32'hFFFF_FFFF.
//  Lookup and update to the same entry in one cycle: lookup returns the OLD value (no bypass).
//  upd_valid_i = 0: no state changes. Mid-operation reset: all state returns to reset values
//   immediately (async); the first post-reset update applies normally.
// CONFIGURATION
//  BRANCH_PRED_GSHARE_EN defined: IDX_W-bit global history register (GHR).
//   Lookup idx = pc_i[IDX_W+1:2] ^ GHR.
//   GHR <= {GHR[IDX_W-2:0], upd_taken_i} on each conditional update (non-speculative).
//   The BHT update still uses upd_idx_i.
//  Undefined: no GHR; idx = pc_i[IDX_W+1:2] (pure bimodal).
// STRUCTURE
//  Package types: bp_ctr_t enum {BP_SNT=2'b00, BP_WNT=2'b01, BP_WT=2'b10, BP_ST=2'b11};
//   btb_entry_t struct {valid, is_cond, tag, target}; BP_CTR_RESET = BP_WNT.
//  Sub-module bp_btb: BTB array with lookup/write ports. BHT, GHR and counters stay in the top.
// TESTING
//  1 Reset, pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104, mispred_cnt_o=0.
//  2 Two taken cond updates, pc 0x100 -> 0x80 -> lookup 0x100: taken, target 0x80;
//    first update mispredict_o=1, cnt=1.
//  3 Four taken, then one not-taken at 0x100 -> still taken (ST->WT);
//    second not-taken -> pred_taken_o=0 (WNT), BTB still hits.
//  4 Jump at 0x200 -> 0x400 (is_cond=0) once -> lookup 0x200 taken regardless of counter;
//    alias 0x240 (BTB16) taken to 0x10 -> 0x200 now misses.
//  5 Same-cycle lookup+update on same entry -> old prediction returned; new one next cycle.
//    Assert rst_n mid-training -> counters WNT, BTB empty.
//  6 GSHARE_EN: alternating T/NT at 0x100, 8 updates -> prediction tracks pattern
//    (no mispredicts after warm-up); without the macro, mispredicts persist.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: 2-bit direction
// counter encoding and the BTB entry layout.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = BP_WNT;

  // Tag is kept at the widest possible size (PC[31:2]) and holds the PC bits
  // above the BTB index, zero-extended, so one struct serves any BTB depth.
  localparam int BP_TAG_W = 30;

  typedef struct packed {
    logic                valid;
    logic                is_cond;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
  } btb_entry_t;

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// registered write port. Only the valid bits are reset; payload is
// qualified by them.
module bp_btb
  import branch_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_is_cond,
  output logic [31:0] lk_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic        wr_is_cond,
  input  logic [31:0] wr_target
);

  localparam int BTB_W = $clog2(BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] valid_q;
  btb_entry_t             mem_q [BTB_ENTRIES];
  btb_entry_t             lk_entry;
  logic [BTB_W-1:0]       lk_idx;
  logic [BTB_W-1:0]       wr_idx;

  function automatic logic [BP_TAG_W-1:0] tag_of(input logic [31:0] pc);
    return BP_TAG_W'(pc >> (BTB_W + 2));
  endfunction

  assign lk_idx = lk_pc[BTB_W+1:2];
  assign wr_idx = wr_pc[BTB_W+1:2];

  // Lookup: hit needs a live slot whose stored tag matches the fetch PC
  always_comb begin
    lk_entry   = mem_q[lk_idx];
    lk_hit     = valid_q[lk_idx] & lk_entry.valid & (lk_entry.tag == tag_of(lk_pc));
    lk_is_cond = lk_entry.is_cond;
    lk_target  = lk_entry.target;
  end

  // Valid bits: cleared by reset, set on every write (aliases simply overwrite)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Entry payload: written on taken resolves, never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= '{valid: 1'b1, is_cond: wr_is_cond,
                         tag: tag_of(wr_pc), target: wr_target};
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: bimodal BHT of 2-bit counters plus a
// direct-mapped BTB (bp_btb). Prediction is combinational on pc_i; training
// happens at resolve time and becomes visible to lookup on the next cycle.
// Optional build macro BRANCH_PRED_GSHARE_EN adds a non-speculative global
// history register that is XORed into the lookup index (gshare).
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter  int BHT_ENTRIES = 64,
  parameter  int BTB_ENTRIES = 16,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_i,
  output logic             pred_taken_o,
  output logic [31:0]      pred_target_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_is_cond_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [31:0]      upd_pred_target_i,
  output logic             mispredict_o,
  output logic [31:0]      mispred_cnt_o
);

  bp_ctr_t          bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] lk_idx;
  logic [1:0]       lk_ctr;
  logic             btb_hit;
  logic             btb_is_cond;
  logic [31:0]      btb_target;
  logic [31:0]      cnt_q;

  // Saturating 2-bit counter step: no wrap past ST or SNT
  function automatic bp_ctr_t ctr_next(input bp_ctr_t c, input logic taken);
    bp_ctr_t n;
    n = c;
    case (c)
      BP_SNT:  n = taken ? BP_WNT : BP_SNT;
      BP_WNT:  n = taken ? BP_WT  : BP_SNT;
      BP_WT:   n = taken ? BP_ST  : BP_WNT;
      BP_ST:   n = taken ? BP_ST  : BP_WT;
      default: n = BP_CTR_RESET;
    endcase
    return n;
  endfunction

  // Saturating event counter: sticks at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

`ifdef BRANCH_PRED_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  assign lk_idx = pc_i[IDX_W+1:2] ^ ghr_q;

  // Global history: shifts in resolved conditional outcomes only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (upd_valid_i && upd_is_cond_i) begin
      ghr_q <= {ghr_q[IDX_W-2:0], upd_taken_i};
    end
  end
`else
  assign lk_idx = pc_i[IDX_W+1:2];
`endif

  bp_btb #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_pc      (pc_i),
    .lk_hit     (btb_hit),
    .lk_is_cond (btb_is_cond),
    .lk_target  (btb_target),
    .wr_en      (upd_valid_i & upd_taken_i),
    .wr_pc      (upd_pc_i),
    .wr_is_cond (upd_is_cond_i),
    .wr_target  (upd_target_i)
  );

  // Prediction: jumps that hit are always taken, branches follow the counter MSB
  always_comb begin
    lk_ctr        = bht_q[lk_idx];
    pred_idx_o    = lk_idx;
    pred_taken_o  = btb_hit & (~btb_is_cond | lk_ctr[1]);
    pred_target_o = btb_hit ? btb_target : pc_i + 32'd4;
  end

  // Resolve-time check: wrong direction, or taken with the wrong target
  always_comb begin
    mispredict_o = upd_valid_i &
                   ((upd_taken_i != upd_pred_taken_i) |
                    (upd_taken_i & (upd_target_i != upd_pred_target_i)));
  end

  // BHT training on conditional resolves; lookup sees it next cycle (no bypass)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= BP_CTR_RESET;
      end
    end else if (upd_valid_i && upd_is_cond_i) begin
      bht_q[upd_idx_i] <= ctr_next(bht_q[upd_idx_i], upd_taken_i);
    end
  end

  // Mispredict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (mispredict_o) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign mispred_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor in its default (bimodal) build.
// Expected values are queued as stimulus is applied and popped when the
// DUT output is sampled, one time unit after the falling edge.
module tb_branch_predictor;

  localparam int IDX_W = 6;

  logic             clk;
  logic             rst_n;
  logic [31:0]      pc_i;
  logic             pred_taken_o;
  logic [31:0]      pred_target_o;
  logic [IDX_W-1:0] pred_idx_o;
  logic             upd_valid_i;
  logic [31:0]      upd_pc_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic             upd_is_cond_i;
  logic             upd_taken_i;
  logic [31:0]      upd_target_i;
  logic             upd_pred_taken_i;
  logic [31:0]      upd_pred_target_i;
  logic             mispredict_o;
  logic [31:0]      mispred_cnt_o;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  branch_predictor dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_i              (pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .pred_idx_o        (pred_idx_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_idx_i         (upd_idx_i),
    .upd_is_cond_i     (upd_is_cond_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .mispredict_o      (mispredict_o),
    .mispred_cnt_o     (mispred_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    push(tag, exp_v);
    pop_chk(obs);
  endtask

  // One cycle: drive lookup PC and an optional resolve, then check mispredict_o
  task automatic step(input logic v, input logic [31:0] upc, input logic cond,
                      input logic tk, input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ptgt, input logic [31:0] pc,
                      input logic exp_mis);
    @(negedge clk);
    pc_i              = pc;
    upd_valid_i       = v;
    upd_pc_i          = upc;
    upd_idx_i         = upc[7:2];
    upd_is_cond_i     = cond;
    upd_taken_i       = tk;
    upd_target_i      = tgt;
    upd_pred_taken_i  = ptk;
    upd_pred_target_i = ptgt;
    push("mispredict", {31'd0, exp_mis});
    #1;
    pop_chk({31'd0, mispredict_o});
  endtask

  task automatic idle(input logic [31:0] pc);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, pc, 1'b0);
  endtask

  task automatic ck_pred(input string tag, input logic exp_tk, input logic [31:0] exp_tgt);
    ck({tag, "_taken"}, {31'd0, pred_taken_o}, {31'd0, exp_tk});
    ck({tag, "_target"}, pred_target_o, exp_tgt);
  endtask

  initial begin
    logic [1:0] mctr;
    logic       actual;
    logic       mpred;

    rst_n = 1'b0;
    pc_i = 32'h100;
    upd_valid_i = 1'b0;
    upd_pc_i = '0;
    upd_idx_i = '0;
    upd_is_cond_i = 1'b0;
    upd_taken_i = 1'b0;
    upd_target_i = '0;
    upd_pred_taken_i = 1'b0;
    upd_pred_target_i = '0;

    // 1: reset state
    #2;
    ck_pred("reset", 1'b0, 32'h104);
    ck("reset_cnt", mispred_cnt_o, 32'd0);
    ck("reset_idx", {26'd0, pred_idx_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: two taken conditional updates 0x100 -> 0x80
    step(1, 32'h100, 1, 1, 32'h80, 0, 32'h104, 32'h100, 1);
    ck("t2_same_cycle_taken", {31'd0, pred_taken_o}, 32'd0);
    idle(32'h100);
    ck("t2_cnt1", mispred_cnt_o, 32'd1);
    ck_pred("t2_wt", 1'b1, 32'h80);
    step(1, 32'h100, 1, 1, 32'h80, 1, 32'h80, 32'h100, 0);
    idle(32'h100);
    ck_pred("t2_st", 1'b1, 32'h80);
    ck("t2_cnt_hold", mispred_cnt_o, 32'd1);

    // 3: saturate, then walk down ST -> WT -> WNT
    step(1, 32'h100, 1, 1, 32'h80, 1, 32'h80, 32'h100, 0);
    step(1, 32'h100, 1, 1, 32'h80, 1, 32'h80, 32'h100, 0);
    step(1, 32'h100, 1, 0, 32'h104, 1, 32'h80, 32'h100, 1);
    idle(32'h100);
    ck_pred("t3_wt", 1'b1, 32'h80);
    ck("t3_cnt2", mispred_cnt_o, 32'd2);
    step(1, 32'h100, 1, 0, 32'h104, 1, 32'h80, 32'h100, 1);
    idle(32'h100);
    ck_pred("t3_wnt_hit", 1'b0, 32'h80);
    ck("t3_cnt3", mispred_cnt_o, 32'd3);

    // upd_valid_i low: no state change, no flag
    step(0, 32'h100, 1, 1, 32'h80, 0, 32'h104, 32'h100, 0);
    idle(32'h100);
    ck("novalid_taken", {31'd0, pred_taken_o}, 32'd0);
    ck("novalid_cnt", mispred_cnt_o, 32'd3);

    // 4: jump 0x200 -> 0x400 evicts 0x100; alias 0x240 evicts 0x200
    idle(32'h200);
    ck_pred("t4_miss", 1'b0, 32'h204);
    step(1, 32'h200, 0, 1, 32'h400, 0, 32'h204, 32'h200, 1);
    idle(32'h200);
    ck_pred("t4_jump", 1'b1, 32'h400);
    ck("t4_cnt4", mispred_cnt_o, 32'd4);
    idle(32'h100);
    ck_pred("t4_evicted_100", 1'b0, 32'h104);
    step(1, 32'h240, 1, 1, 32'h10, 0, 32'h244, 32'h240, 1);
    idle(32'h200);
    ck_pred("t4_alias_miss", 1'b0, 32'h204);
    ck("t4_cnt5", mispred_cnt_o, 32'd5);
    idle(32'h240);
    ck_pred("t4_alias_hit", 1'b1, 32'h10);
    ck("t4_alias_idx", {26'd0, pred_idx_o}, 32'd16);

    // target-only mispredict: direction right, target wrong
    step(1, 32'h240, 1, 1, 32'h20, 1, 32'h10, 32'h240, 1);
    idle(32'h240);
    ck_pred("tgt_mis", 1'b1, 32'h20);
    ck("tgt_mis_cnt", mispred_cnt_o, 32'd6);

    // 5: same-cycle lookup and update return the old value
    step(1, 32'h240, 1, 0, 32'h244, 1, 32'h20, 32'h240, 1);
    ck("t5_old_st", {31'd0, pred_taken_o}, 32'd1);
    step(1, 32'h240, 1, 0, 32'h244, 1, 32'h20, 32'h240, 1);
    ck("t5_old_wt", {31'd0, pred_taken_o}, 32'd1);
    idle(32'h240);
    ck_pred("t5_new_wnt", 1'b0, 32'h20);
    step(1, 32'h240, 0, 1, 32'h30, 0, 32'h20, 32'h240, 1);
    ck_pred("t5_old_btb", 1'b0, 32'h20);
    idle(32'h240);
    ck_pred("t5_new_btb", 1'b1, 32'h30);
    ck("t5_cnt9", mispred_cnt_o, 32'd9);

    // mid-training async reset
    step(1, 32'h100, 1, 1, 32'h80, 0, 32'h104, 32'h100, 1);
    step(1, 32'h100, 1, 1, 32'h80, 1, 32'h80, 32'h100, 0);
    @(negedge clk);
    pc_i = 32'h100;
    upd_valid_i = 1'b1;
    upd_taken_i = 1'b1;
    upd_pred_taken_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    ck("rst_cnt", mispred_cnt_o, 32'd0);
    ck_pred("rst_btb_empty", 1'b0, 32'h104);
    @(negedge clk);
    upd_valid_i = 1'b0;
    rst_n = 1'b1;
    #1;
    ck("rst_cnt_hold", mispred_cnt_o, 32'd0);
    step(1, 32'h100, 1, 1, 32'h80, 0, 32'h104, 32'h100, 1);
    idle(32'h100);
    ck_pred("post_rst_wt", 1'b1, 32'h80);
    ck("post_rst_cnt1", mispred_cnt_o, 32'd1);
    step(1, 32'h100, 1, 0, 32'h104, 1, 32'h80, 32'h100, 1);
    idle(32'h100);
    ck_pred("post_rst_wnt", 1'b0, 32'h80);
    ck("post_rst_cnt2", mispred_cnt_o, 32'd2);

    // 6: alternating T/NT at 0x100 keeps a bimodal counter mispredicting
    mctr = 2'b01;
    for (int i = 0; i < 8; i++) begin
      actual = ((i % 2) == 0);
      mpred  = mctr[1];
      idle(32'h100);
      ck("alt_pred", {31'd0, pred_taken_o}, {31'd0, mpred});
      step(1, 32'h100, 1, actual, actual ? 32'h80 : 32'h104, mpred,
           mpred ? 32'h80 : 32'h104, 32'h100, mpred != actual);
      if (actual && mctr != 2'b11) mctr = mctr + 2'b01;
      else if (!actual && mctr != 2'b00) mctr = mctr - 2'b01;
    end
    idle(32'h100);
    ck("alt_cnt", mispred_cnt_o, 32'd10);
    ck("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
